// File: rtl/game_pkg.sv
// Shared encodings for the pingpong game: game_state bus, winner code and defaults.
package game_pkg;

  // game_state bus encoding, also decoded by the countdown timer and ball logic
  typedef enum logic [1:0] {
    ST_P1_SERVE = 2'd0,
    ST_P2_SERVE = 2'd1,
    ST_PLAYING  = 2'd2,
    ST_DONE     = 2'd3
  } game_state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_P1   = 2'd1,
    WIN_P2   = 2'd2,
    WIN_DRAW = 2'd3
  } winner_e;

  localparam int unsigned DEF_WIN_SCORE    = 11;
  localparam int unsigned DEF_SERVE_SWITCH = 2;

  // Winner by comparing scores; used when the match ends on time
  function automatic winner_e decide_winner(input logic [3:0] s1, input logic [3:0] s2);
    if (s1 > s2) begin
      return WIN_P1;
    end else if (s2 > s1) begin
      return WIN_P2;
    end
    return WIN_DRAW;
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Signal bundle between the rally sequencer and its surroundings (buttons, court, timer).
interface game_ctrl_if;
  logic       p1_btn;
  logic       p2_btn;
  logic       restart_btn;
  logic       miss_p1;
  logic       miss_p2;
  logic [5:0] time_cnt;
  logic [1:0] game_state;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       serve_launch;
  logic       serve_dir;
  logic [1:0] winner;

  // Sequencer side
  modport master (
    input  p1_btn, p2_btn, restart_btn, miss_p1, miss_p2, time_cnt,
    output game_state, score_p1, score_p2, serve_launch, serve_dir, winner
  );

  // Environment side
  modport slave (
    output p1_btn, p2_btn, restart_btn, miss_p1, miss_p2, time_cnt,
    input  game_state, score_p1, score_p2, serve_launch, serve_dir, winner
  );
endinterface

// File: rtl/btn_edge.sv
// Registered rising-edge detector for one debounced button.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  logic prev_q;
  // armed_q stays low for the first cycle after reset so a button held through
  // reset is absorbed into prev_q instead of firing.
  logic armed_q;

  // Track previous button level and arm after the first post-reset clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= btn_i;
      armed_q <= 1'b1;
    end
  end

  assign rise_o = btn_i & ~prev_q & armed_q;

endmodule

// File: rtl/game_ctrl.sv
// Rally sequencer: serve/play/done state, scores, serve alternation and match end.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
  parameter int unsigned SERVE_SWITCH = DEF_SERVE_SWITCH
) (
  input logic        clk,
  input logic        reset,
  game_ctrl_if.master bus
);

  localparam logic [3:0] WinScore  = 4'(WIN_SCORE);
  localparam logic [3:0] SwitchCnt = 4'(SERVE_SWITCH);

  logic p1_rise, p2_rise, restart_rise;

  btn_edge u_p1_edge (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.p1_btn),
    .rise_o (p1_rise)
  );

  btn_edge u_p2_edge (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.p2_btn),
    .rise_o (p2_rise)
  );

  btn_edge u_restart_edge (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (bus.restart_btn),
    .rise_o (restart_rise)
  );

  game_state_e state_q;
  logic [3:0]  score_p1_q, score_p2_q, score_p1_d, score_p2_d;
  logic [3:0]  pt_q, pt_d;
  logic        server_q, server_d;  // 0 = P1 serves, 1 = P2 serves
  winner_e     winner_q;
  logic        launch_q;
  logic        dir_q;

  logic        p1_point, p2_point, any_miss, time_zero, win_hit;
  game_state_e serve_state;

  // Point bookkeeping for a miss event during a rally
  always_comb begin
    p1_point   = bus.miss_p2 & ~bus.miss_p1;
    p2_point   = bus.miss_p1 & ~bus.miss_p2;
    any_miss   = bus.miss_p1 | bus.miss_p2;
    time_zero  = (bus.time_cnt == 6'd0);
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    pt_d       = pt_q;
    server_d   = server_q;
    if (p1_point && score_p1_q < WinScore) begin
      score_p1_d = score_p1_q + 4'd1;
    end
    if (p2_point && score_p2_q < WinScore) begin
      score_p2_d = score_p2_q + 4'd1;
    end
    if (p1_point || p2_point) begin
      if (pt_q + 4'd1 == SwitchCnt) begin
        pt_d     = 4'd0;
        server_d = ~server_q;
      end else begin
        pt_d = pt_q + 4'd1;
      end
    end
    win_hit     = (p1_point && score_p1_d == WinScore) || (p2_point && score_p2_d == WinScore);
    serve_state = server_d ? ST_P2_SERVE : ST_P1_SERVE;
  end

  // Game FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_P1_SERVE;
      score_p1_q <= 4'd0;
      score_p2_q <= 4'd0;
      pt_q       <= 4'd0;
      server_q   <= 1'b0;
      winner_q   <= WIN_NONE;
      launch_q   <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      launch_q <= 1'b0;
      unique case (state_q)
        ST_P1_SERVE, ST_P2_SERVE: begin
          // Timeout takes priority over a serve in the same cycle
          if (time_zero) begin
            state_q  <= ST_DONE;
            winner_q <= decide_winner(score_p1_q, score_p2_q);
          end else if (state_q == ST_P1_SERVE && p1_rise) begin
            state_q  <= ST_PLAYING;
            launch_q <= 1'b1;
            dir_q    <= 1'b0;
          end else if (state_q == ST_P2_SERVE && p2_rise) begin
            state_q  <= ST_PLAYING;
            launch_q <= 1'b1;
            dir_q    <= 1'b1;
          end
        end
        ST_PLAYING: begin
          score_p1_q <= score_p1_d;
          score_p2_q <= score_p2_d;
          pt_q       <= pt_d;
          server_q   <= server_d;
          if (win_hit) begin
            state_q  <= ST_DONE;
            winner_q <= p1_point ? WIN_P1 : WIN_P2;
          end else if (time_zero) begin
            state_q  <= ST_DONE;
            winner_q <= decide_winner(score_p1_d, score_p2_d);
          end else if (any_miss) begin
            state_q <= serve_state;
          end
        end
        ST_DONE: begin
          if (restart_rise) begin
            state_q    <= ST_P1_SERVE;
            score_p1_q <= 4'd0;
            score_p2_q <= 4'd0;
            pt_q       <= 4'd0;
            server_q   <= 1'b0;
            winner_q   <= WIN_NONE;
          end
        end
      endcase
    end
  end

  assign bus.game_state   = state_q;
  assign bus.score_p1     = score_p1_q;
  assign bus.score_p2     = score_p2_q;
  assign bus.serve_launch = launch_q;
  assign bus.serve_dir    = dir_q;
  assign bus.winner       = winner_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Top-level rally sequencer for the pingpong game. Owns the 2-bit game_state bus consumed by the countdown timer and ball logic, keeps both players' scores and alternates the serve. Ends the match on a score win or on timer expiry, and restarts on request. Sits between the debounced buttons, the ball/court logic (miss events) and the timer (time_cnt).

Parameters:
WIN_SCORE, 11, points needed to win; legal range 1..15.
SERVE_SWITCH, 2, total points scored between serve hand-overs; legal range 1..15.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low
p1_btn  input  1  player-1 serve button, synchronised and debounced, high = pressed
p2_btn  input  1  player-2 serve button, same rules as p1_btn
restart_btn  input  1  restart button, same rules as p1_btn
miss_p1  input  1  one-cycle pulse: ball passed player 1, so player 2 scores
miss_p2  input  1  one-cycle pulse: ball passed player 2, so player 1 scores
time_cnt  input  6  remaining seconds from the timer
game_state  output  2  0 = P1_SERVE, 1 = P2_SERVE, 2 = PLAYING, 3 = DONE
score_p1  output  4  player-1 score
score_p2  output  4  player-2 score
serve_launch  output  1  one-cycle pulse that releases the ball
serve_dir  output  1  direction of the current rally: 0 = toward P2, 1 = toward P1
winner  output  2  0 = none, 1 = P1, 2 = P2, 3 = draw

Behaviour:
- Reset (asynchronous, active-low):
  - game_state = P1_SERVE; scores = 0; winner = 0; serve_launch = 0; serve_dir = 0.
  - Internal server = P1; internal point counter pt_cnt = 0; button history registers = 0.
- Buttons: act on the rising edge only, detected against a registered copy of each button.
  - A button held through reset does not fire on reset release.
- All outputs are registered. Each transition below takes effect on the clock edge after the triggering input is sampled.
- P1_SERVE:
  - p1 rising edge -> PLAYING; serve_launch = 1 for exactly 1 cycle; serve_dir = 0.
  - p2 and restart edges are ignored.
- P2_SERVE: mirror of P1_SERVE; p2 rising edge -> PLAYING with serve_dir = 1.
- PLAYING:
  - miss_p1 alone -> score_p2 + 1.
  - miss_p2 alone -> score_p1 + 1.
  - miss_p1 and miss_p2 in the same cycle -> let rally: no score change, pt_cnt unchanged, return to the current server's serve state.
  - After a point: pt_cnt + 1. When pt_cnt reaches SERVE_SWITCH, clear it to 0 and toggle the server. Next state is the new server's serve state.
  - If the updated score equals WIN_SCORE -> DONE instead, with winner set to the scorer.
- Timeout: time_cnt == 0 in any state except DONE -> DONE.
  - winner = higher score; equal scores -> 3.
  - If a point and the timeout arrive in the same cycle, the point is applied first and the winner is decided on the updated scores.
- DONE:
  - Scores and winner hold; miss pulses and serve buttons are ignored.
  - restart rising edge -> scores, pt_cnt and winner cleared; server = P1; state = P1_SERVE.
  - DONE lasts at least 1 cycle, so the timer sees state 3 and reloads to 60 before play resumes.
- Scores saturate at WIN_SCORE and never wrap.
- time_cnt is checked only for equality with 0. Values above 60 are treated as nonzero.
- Miss pulses in serve states are ignored.

Decomposition:
- Shared package game_pkg holds:
  - the game_state encodings (ST_P1_SERVE = 2'd0, ST_P2_SERVE = 2'd1, ST_PLAYING = 2'd2, ST_DONE = 2'd3), shared with the timer and ball logic;
  - the winner encodings;
  - the default WIN_SCORE.
- One sub-module, btn_edge: a per-button registered rising-edge detector. game_ctrl instantiates it 3 times.

Test Plan:
1. Release reset with time_cnt = 60; pulse p1_btn -> game_state goes 0 -> 2; serve_launch high for exactly 1 cycle; serve_dir = 0.
2. With SERVE_SWITCH = 2: miss_p2, serve, then miss_p2 -> score_p1 = 2, game_state = 1 (P2 serves). p1_btn then does nothing; p2_btn gives serve_dir = 1.
3. miss_p1 and miss_p2 in the same cycle during PLAYING -> scores unchanged; return to the same server's state.
4. With WIN_SCORE = 3, player 1 scores 3 points -> game_state = 3, winner = 1. Further miss pulses leave score_p1 = 3.
5. At 2-2, drive time_cnt = 0 together with miss_p2 -> score_p1 = 3 and winner = 1. Repeat the run without the miss -> winner = 3 (draw).
6. In DONE, a restart edge -> all scores 0, winner = 0, game_state = 0. Assert reset mid-PLAYING -> every output returns to its reset value immediately.
